// File: rtl/BG1_pkg.sv
// BG1_pkg: base graph 1 dimensions.
package BG1_pkg;
    localparam int BG1_MSG_COL_COUNT = 22;
endpackage

// File: rtl/BG2_pkg.sv
// BG2_pkg: base graph 2 dimensions.
package BG2_pkg;
    localparam int BG2_MSG_COL_COUNT = 10;
endpackage

// File: rtl/LDPC_pkg.sv
// LDPC_pkg: shared LDPC sizes, base-graph select and syndrome-check FSM states.
package LDPC_pkg;
    localparam int MAX_ZC         = 384;
    localparam int GAP_COLS_COUNT = 4;
    localparam int CORE_PAR_COLS  = 4;
    localparam int MAX_ZC_VALID   = 384;
    typedef enum logic [1:0] {BG_NONE = 2'd0, BG1 = 2'd1, BG2 = 2'd2, BG_RSVD = 2'd3} BG_Type;
    typedef enum logic [1:0] {IDLE, ACCUM, EVAL, DONE} syn_state_t;
endpackage

// File: rtl/ldpc_core_syndrome_check_if.sv
// ldpc_core_syndrome_check_if: config, column-beat and result signals of the core syndrome check.
interface ldpc_core_syndrome_check_if;
    import LDPC_pkg::*;
    logic                                     start;
    BG_Type                                   BG;
    logic [8:0]                               zc;
    logic                                     col_valid;
    logic [GAP_COLS_COUNT-1:0][MAX_ZC-1:0]    shifted_cw_block;
    logic                                     busy;
    logic                                     check_done;
    logic                                     syndrome_ok;
    logic [3:0]                               row_fail;
    logic                                     cfg_err;
    modport master (
        output start, BG, zc, col_valid, shifted_cw_block,
        input  busy, check_done, syndrome_ok, row_fail, cfg_err
    );
    modport slave (
        input  start, BG, zc, col_valid, shifted_cw_block,
        output busy, check_done, syndrome_ok, row_fail, cfg_err
    );
endinterface

// File: rtl/zc_lsb_mask.sv
// zc_lsb_mask: sets the low zc bits of a MAX_ZC-wide mask (saturates to all ones).
module zc_lsb_mask
    import LDPC_pkg::*;
(
    input  logic [8:0]        zc,
    output logic [MAX_ZC-1:0] mask
);
    assign mask = ~({MAX_ZC{1'b1}} << zc);
endmodule

// File: rtl/ldpc_core_syndrome_check.sv
// ldpc_core_syndrome_check: XOR-accumulates core rows 0..3 over one codeword's
// columns and reports per-row nonzero syndromes within the active lifting size.
module ldpc_core_syndrome_check
    import LDPC_pkg::*;
    import BG1_pkg::*;
    import BG2_pkg::*;
(
    input logic                        clk,
    input logic                        reset_n,
    ldpc_core_syndrome_check_if.slave  sc
);
    syn_state_t                            state, state_nxt;
    logic [GAP_COLS_COUNT-1:0][MAX_ZC-1:0] acc;
    logic [4:0]                            col_cnt;
    logic [8:0]                            zc_q;
    BG_Type                                bg_q;
    logic [MAX_ZC-1:0]                     zc_mask;
    logic [4:0]                            n_cols;
    logic                                  cfg_ok;
    logic                                  last_beat;
    logic [GAP_COLS_COUNT-1:0]             row_nz;

    zc_lsb_mask u_mask (.zc(zc_q), .mask(zc_mask));

    always_comb begin
        cfg_ok    = (sc.BG == BG1 || sc.BG == BG2) && sc.zc >= 9'd2 && sc.zc <= 9'(MAX_ZC_VALID);
        n_cols    = (bg_q == BG1) ? 5'(BG1_MSG_COL_COUNT + CORE_PAR_COLS)
                                  : 5'(BG2_MSG_COL_COUNT + CORE_PAR_COLS);
        last_beat = sc.col_valid && (col_cnt + 5'd1 == n_cols);
        for (int r = 0; r < GAP_COLS_COUNT; r++)
            row_nz[r] = |(acc[r] & zc_mask);
        state_nxt = (state == IDLE)  ? (sc.start ? (cfg_ok ? ACCUM : DONE) : IDLE) :
                    (state == ACCUM) ? (last_beat ? EVAL : ACCUM) :
                    (state == EVAL)  ? DONE : IDLE;
    end

    // An invalid config still latches and reports through DONE so the caller sees check_done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            acc            <= '0;
            col_cnt        <= '0;
            zc_q           <= '0;
            bg_q           <= BG_NONE;
            sc.busy        <= 1'b0;
            sc.check_done  <= 1'b0;
            sc.syndrome_ok <= 1'b0;
            sc.row_fail    <= '0;
            sc.cfg_err     <= 1'b0;
        end else begin
            state         <= state_nxt;
            sc.busy       <= state_nxt != IDLE;
            sc.check_done <= state_nxt == DONE;
            if (state == IDLE && sc.start) begin
                acc            <= '0;
                col_cnt        <= '0;
                zc_q           <= sc.zc;
                bg_q           <= sc.BG;
                sc.syndrome_ok <= 1'b0;
                sc.row_fail    <= '0;
                sc.cfg_err     <= !cfg_ok;
            end
            if (state == ACCUM && sc.col_valid) begin
                acc     <= acc ^ sc.shifted_cw_block;
                col_cnt <= (col_cnt == 5'd31) ? col_cnt : col_cnt + 5'd1;
            end
            if (state == EVAL) begin
                sc.row_fail    <= row_nz;
                sc.syndrome_ok <= ~|row_nz;
            end
        end
    end
endmodule

// File: tb/tb_ldpc_core_syndrome_check.sv
// tb_ldpc_core_syndrome_check: directed table plus randomized codewords checked
// against a per-bit parity model of the four core rows.
module tb_ldpc_core_syndrome_check;
    import LDPC_pkg::*;

    typedef logic [GAP_COLS_COUNT-1:0][MAX_ZC-1:0] blk_t;
    typedef struct {
        string      name;
        BG_Type     bg;
        logic [8:0] zc;
        int         pat;
        bit         bub;
        bit         ext;
        bit         eok;
        logic [3:0] erf;
        bit         ecfg;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    blk_t beats[32];
    vec_t tbl[13];

    ldpc_core_syndrome_check_if sc();
    ldpc_core_syndrome_check dut (.clk(clk), .reset_n(reset_n), .sc(sc));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic blk_t rand_blk();
        blk_t b;
        for (int r = 0; r < GAP_COLS_COUNT; r++)
            for (int w = 0; w < MAX_ZC / 32; w++)
                b[r][w*32 +: 32] = $urandom;
        return b;
    endfunction

    // 0 all-zero, 1 valid codeword with row 2 bit 0 flipped in column 5,
    // 2 bit 300 set in all rows of one column, 3 valid codeword with an optional edge flip
    task automatic build(input int pat, input int n, input int zc);
        blk_t x;
        int   c, r;
        x = '0;
        for (int i = 0; i < 32; i++) beats[i] = '0;
        if (pat == 2)
            for (int k = 0; k < GAP_COLS_COUNT; k++) beats[3][k][300] = 1'b1;
        if (pat == 1 || pat == 3) begin
            for (int i = 0; i < n - 1; i++) begin
                beats[i] = rand_blk();
                x = x ^ beats[i];
            end
            beats[n-1] = x;
        end
        if (pat == 1) beats[5][2][0] = ~beats[5][2][0];
        if (pat == 3) begin
            c = $urandom_range(0, n - 1);
            r = $urandom_range(0, GAP_COLS_COUNT - 1);
            case ($urandom_range(0, 2))
                1: beats[c][r][zc-1] = ~beats[c][r][zc-1];
                2: if (zc < MAX_ZC) beats[c][r][zc] = ~beats[c][r][zc];
                default: ;
            endcase
        end
    endtask

    // Row r fails when some bit position below zc has odd parity over the n columns
    function automatic logic [3:0] model_rf(input int n, input int zc);
        logic [3:0] rf;
        logic       p;
        rf = '0;
        for (int r = 0; r < GAP_COLS_COUNT; r++)
            for (int b = 0; b < zc && b < MAX_ZC; b++) begin
                p = 1'b0;
                for (int c = 0; c < n; c++) p = p ^ beats[c][r][b];
                if (p) rf[r] = 1'b1;
            end
        return rf;
    endfunction

    task automatic run_check(input string nm, input BG_Type bg, input logic [8:0] zc,
                             input bit bub, input bit ext, input bit eok,
                             input logic [3:0] erf, input bit ecfg);
        int n;
        int done_k;
        int n_done;
        n = (bg == BG1) ? 26 : 14;
        done_k = -1;
        n_done = 0;
        sc.start = 1'b1;
        sc.BG = bg;
        sc.zc = zc;
        sc.col_valid = 1'b0;
        @(negedge clk);
        sc.start = 1'b0;
        if (ecfg) begin
            chk({nm, "/done_t1"}, 32'(sc.check_done), 1);
            chk({nm, "/cfg_err"}, 32'(sc.cfg_err), 1);
            chk({nm, "/syndrome_ok"}, 32'(sc.syndrome_ok), 0);
            chk({nm, "/row_fail"}, 32'(sc.row_fail), 0);
            @(negedge clk);
            chk({nm, "/idle_busy"}, 32'(sc.busy), 0);
            return;
        end
        chk({nm, "/busy_t1"}, 32'(sc.busy), 1);
        chk({nm, "/cfg_err"}, 32'(sc.cfg_err), 0);
        for (int c = 0; c < n; c++) begin
            sc.col_valid = 1'b1;
            sc.shifted_cw_block = beats[c];
            @(negedge clk);
            if (bub && c < n - 1) begin
                sc.col_valid = 1'b0;
                sc.shifted_cw_block = rand_blk();
                @(negedge clk);
            end
        end
        chk({nm, "/busy_last"}, 32'(sc.busy), 1);
        chk({nm, "/done_early"}, 32'(sc.check_done), 0);
        for (int k = 0; k < 4; k++) begin
            sc.start = ext && k < 2;
            sc.col_valid = ext && k < 3;
            sc.shifted_cw_block = rand_blk();
            @(negedge clk);
            if (sc.check_done) begin
                n_done++;
                if (done_k < 0) done_k = k;
            end
        end
        sc.start = 1'b0;
        sc.col_valid = 1'b0;
        chk({nm, "/done_latency"}, 32'(done_k), 0);
        chk({nm, "/done_pulses"}, 32'(n_done), 1);
        chk({nm, "/busy_end"}, 32'(sc.busy), 0);
        chk({nm, "/syndrome_ok"}, 32'(sc.syndrome_ok), 32'(eok));
        chk({nm, "/row_fail"}, 32'(sc.row_fail), 32'(erf));
        chk({nm, "/cfg_err_end"}, 32'(sc.cfg_err), 0);
    endtask

    initial begin
        BG_Type     rbg;
        logic [8:0] rzc;
        logic [3:0] rf;
        sc.start = 1'b0;
        sc.BG = BG1;
        sc.zc = '0;
        sc.col_valid = 1'b0;
        sc.shifted_cw_block = '0;
        repeat (2) @(negedge clk);
        chk("rst/busy", 32'(sc.busy), 0);
        chk("rst/check_done", 32'(sc.check_done), 0);
        chk("rst/syndrome_ok", 32'(sc.syndrome_ok), 0);
        chk("rst/row_fail", 32'(sc.row_fail), 0);
        chk("rst/cfg_err", 32'(sc.cfg_err), 0);
        reset_n = 1'b1;
        @(negedge clk);

        tbl = '{
            '{"zero_bg2_384",     BG2,             9'd384, 0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0},
            '{"flip_bg1_208",     BG1,             9'd208, 1, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0},
            '{"bit300_masked",    BG1,             9'd208, 2, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0},
            '{"bit300_in_range",  BG2,             9'd301, 2, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0},
            '{"zc0",              BG1,             9'd0,   0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1},
            '{"zc400",            BG1,             9'd400, 0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1},
            '{"zc1",              BG2,             9'd1,   0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1},
            '{"zc385",            BG2,             9'd385, 0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1},
            '{"bg_invalid",       BG_Type'(2'd3),  9'd100, 0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1},
            '{"flip_bg2_nobub",   BG2,             9'd100, 1, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0},
            '{"flip_bg2_bub_ext", BG2,             9'd100, 1, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b0},
            '{"flip_bg1_zc2",     BG1,             9'd2,   1, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0},
            '{"zero_bg1_zc2_ext", BG1,             9'd2,   0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0}
        };
        foreach (tbl[i]) begin
            build(tbl[i].pat, (tbl[i].bg == BG1) ? 26 : 14, int'(tbl[i].zc));
            run_check(tbl[i].name, tbl[i].bg, tbl[i].zc, tbl[i].bub, tbl[i].ext,
                      tbl[i].eok, tbl[i].erf, tbl[i].ecfg);
        end

        for (int i = 0; i < 10; i++) begin
            rbg = $urandom_range(0, 1) ? BG1 : BG2;
            rzc = 9'($urandom_range(2, 384));
            build(3, (rbg == BG1) ? 26 : 14, int'(rzc));
            rf = model_rf((rbg == BG1) ? 26 : 14, int'(rzc));
            run_check($sformatf("rand%0d", i), rbg, rzc, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), rf == 4'b0, rf, 1'b0);
        end

        // Reset in the middle of a BG1 check, then a fresh clean run
        build(3, 26, 100);
        sc.start = 1'b1;
        sc.BG = BG1;
        sc.zc = 9'd100;
        @(negedge clk);
        sc.start = 1'b0;
        for (int c = 0; c < 7; c++) begin
            sc.col_valid = 1'b1;
            sc.shifted_cw_block = beats[c];
            @(negedge clk);
        end
        sc.col_valid = 1'b0;
        chk("midrst/busy_before", 32'(sc.busy), 1);
        reset_n = 1'b0;
        #1;
        chk("midrst/busy", 32'(sc.busy), 0);
        chk("midrst/check_done", 32'(sc.check_done), 0);
        chk("midrst/syndrome_ok", 32'(sc.syndrome_ok), 0);
        chk("midrst/row_fail", 32'(sc.row_fail), 0);
        chk("midrst/cfg_err", 32'(sc.cfg_err), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("midrst/idle_busy", 32'(sc.busy), 0);
        build(0, 26, 384);
        run_check("post_reset_zero", BG1, 9'd384, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ldpc_core_syndrome_check.md
# ldpc_core_syndrome_check

Receive-side counterpart of the encoder's gap-parity evaluation. It accumulates the four core parity-check rows (rows 0..3 of BG1/BG2) over a received codeword, one base-graph column per accepted beat, and reports whether each row's syndrome is zero within the active lifting size. It sits after the decoder-side column shifter and before the LDPC decoder's early-termination and pass/fail logic.

## Interface
- Parameters: none; `MAX_ZC` (384) and `GAP_COLS_COUNT` (4) come from `LDPC_pkg`.
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; latches `BG` and `zc` and begins a check
- `BG`  in  `BG_Type`  base graph select, sampled on `start`
- `zc`  in  9  lifting size, sampled on `start`; valid range 2..384
- `col_valid`  in  1  current column beat valid
- `shifted_cw_block`  in  `[MAX_ZC-1:0]` × `GAP_COLS_COUNT`  column's codeword block, already circularly shifted per row (all-zero for a null entry)
- `busy`  out  1  high from the cycle after an accepted `start` until `check_done`
- `check_done`  out  1  one-cycle completion pulse
- `syndrome_ok`  out  1  all four rows zero; held until the next accepted `start`
- `row_fail`  out  4  bit r set when row r's syndrome is nonzero; held like `syndrome_ok`
- `cfg_err`  out  1  latched `BG`/`zc` invalid; held like `syndrome_ok`

## Operation
- FSM states: IDLE, ACCUM, EVAL, DONE.
- **IDLE**
  - `start=1`: clear the accumulators, `col_cnt`, and the result outputs, and latch config.
  - Valid config → ACCUM. Invalid config (`BG` neither BG1 nor BG2, `zc`<2, or `zc`>384) → DONE with `cfg_err=1`.
  - `col_valid` is ignored in IDLE.
- **Column count:** `n_cols` = `BG1_MSG_COL_COUNT`+4 = 26 for BG1, or `BG2_MSG_COL_COUNT`+4 = 14 for BG2. This covers the message columns plus the 4 core parity columns.
- **ACCUM**
  - Each cycle with `col_valid=1`: `acc[r] <= acc[r] ^ shifted_cw_block[r]` for r=0..3, and `col_cnt` increments. The counter is 5 bits and saturates at 31.
  - `col_valid=0` cycles are bubbles and change nothing.
  - The beat that makes `col_cnt == n_cols` moves the FSM to EVAL. Any further `col_valid` is ignored.
- **EVAL**
  - `row_fail[r] <= |(acc[r] & zc_mask)`, where `zc_mask` has its low `zc` bits set.
  - `syndrome_ok <= ~|` of the four masked rows.
  - Bits at index ≥ `zc` never contribute.
- **DONE**
  - `check_done=1` for one cycle, then → IDLE.
  - `start` in ACCUM, EVAL, or DONE is ignored; there is no abort or restart mid-check.
- **Reset** (any state): FSM → IDLE, and accumulators, `col_cnt`, and all outputs go to 0.

## Timing
- Reset values: `busy=0`, `check_done=0`, `syndrome_ok=0`, `row_fail=0`, `cfg_err=0`.
- Accepted `start` at cycle t: `busy=1` from t+1.
- Last column beat at cycle c: EVAL at c+1, and results plus `check_done` are visible at c+2. `busy` drops at c+3.
- Invalid config: `check_done` at t+1, with `row_fail=0` and `syndrome_ok=0`.
- Minimum check length with back-to-back beats:
  - BG1: 26+3 cycles
  - BG2: 14+3 cycles
- A new `start` is accepted the cycle after `check_done` (IDLE).
- All outputs are registered. The mask is combinational from the latched `zc`.

## Structure
- `LDPC_pkg` holds the shared definitions: `MAX_ZC`, `GAP_COLS_COUNT`, `BG_Type`, and the new constants `CORE_PAR_COLS=4` and `MAX_ZC_VALID=384`.
- `BG1_MSG_COL_COUNT` and `BG2_MSG_COL_COUNT` stay in `BG1_pkg` and `BG2_pkg`.
- FSM state typedef `syn_state_t` goes in `LDPC_pkg`.
- One sub-module, `zc_lsb_mask`: pure combinational, input 9-bit `zc`, output `[MAX_ZC-1:0]` with bits `[zc-1:0]` set. The encoder side may reuse it.

## Test plan
- All-zero codeword, BG2, `zc`=384, 14 consecutive beats → `check_done` 2 cycles after the last beat; `syndrome_ok=1`, `row_fail=4'b0000`.
- BG1, `zc`=208, with a valid codeword's column blocks except bit 0 of row 2 flipped in column 5 → `syndrome_ok=0`, `row_fail=4'b0100`.
- BG1, `zc`=208, a beat with bit 300 set in all four rows, all else zero → `syndrome_ok=1` (out-of-range bits masked).
- `start` with `zc`=0, then separately `zc`=400 → `check_done` at t+1, `cfg_err=1`, `syndrome_ok=0`.
- BG2 run with `col_valid` bubbles after every beat, plus a `start` pulse and 3 extra beats after beat 14 → results identical to the no-bubble run; extras and `start` ignored.
- `reset_n` low after 7 of 26 BG1 beats → all outputs 0 and IDLE. A fresh all-zero BG1 run then gives `syndrome_ok=1`.
